gray_code_counter: RTL and testbench
====================================

Name: gray_code_counter

Overview:
- Synchronous binary-to-Gray encoding counter: an internal binary count is re-encoded into reflected-binary Gray code every cycle.
- This is the encoder-side counterpart of the team's combinational Gray-to-binary decoder.
- Typical use: generating pointers that change one bit per step, for example FIFO pointers sent across a clock domain, then decoded back to binary at the far end.
- Supports up/down counting, parallel load and a wrap pulse.

Parameters:
- WIDTH, 4, bit width of the binary count and of the Gray output (legal range 2..16).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  advances the count one step on this edge when high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when enable=1.
- load  input  1  synchronous parallel load; has priority over enable.
- load_bin  input  WIDTH  binary value taken on load.
- bin  output  WIDTH  registered binary count.
- gray  output  WIDTH  registered Gray code of bin.
- wrap  output  1  one-cycle pulse; high the cycle after the count rolls over.

Behaviour:
- Reset (asynchronous, active-high):
  - bin=0, gray=0, wrap=0 immediately, with no clock edge required.
  - Outputs hold at these values while reset is high.
  - First update occurs on the first rising clock edge after reset deasserts.
- All state is updated on the rising clock edge only. Every output is a register; there is no combinational path from inputs to outputs.
- Encoding rule: gray = bin XOR (bin >> 1), with the MSB passed through.
- gray is computed from the next-state binary value and registered on the same edge as bin. bin and gray are therefore always mutually consistent, with no lag cycle.
- Priority per edge: load > enable > hold.
  - load=1:
    - bin <= load_bin.
    - gray <= encode(load_bin).
    - wrap <= 0.
    - enable and up are ignored.
  - load=0, enable=1, up=1:
    - bin <= (bin+1) mod 2^WIDTH.
    - wrap <= 1 if bin was all-ones, else 0.
  - load=0, enable=1, up=0:
    - bin <= (bin-1) mod 2^WIDTH.
    - wrap <= 1 if bin was 0, else 0.
  - load=0, enable=0:
    - bin and gray hold.
    - wrap <= 0.
- Latency: 1 cycle from a sampled enable or load to updated bin and gray.
- One-bit-change property:
  - Every enable step, in either direction and including wrap-around, changes exactly one bit of gray.
  - A load may change any number of bits.
  - A direction change on consecutive steps is legal and also changes exactly one bit.
- wrap:
  - Never high for two consecutive cycles unless two consecutive wrap steps occur. Example: WIDTH counts of up/down alternation at the boundary, 1111 -> 0000 -> 1111 with up then down, yields wrap on both.
- Reset asserted mid-operation:
  - Any pending load or step is abandoned.
  - Outputs go to zero asynchronously.
- Arithmetic: modular, WIDTH bits. No saturation and no overflow flag beyond wrap.

Test Plan (WIDTH=4):
- Reset, then hold enable=1, up=1 for 16 cycles.
  - gray sequence: 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000.
  - wrap=1 only after the 1111->0000 step.
  - bin/gray relationship holds every cycle.
- From reset, enable=1, up=0 for one cycle.
  - Result: bin=1111, gray=1000, wrap=1.
  - Next down step: bin=1110, gray=1001, wrap=0.
- load=1, load_bin=0101, enable=1, up=1 in the same cycle.
  - Load wins: bin=0101, gray=0111, wrap=0.
  - Following up step: bin=0110, gray=0101.
- Count up to bin=0111 (gray=0100), then deassert enable for 5 cycles.
  - Outputs hold at 0111/0100 with wrap=0.
  - Alternate up and down steps: gray toggles between 0100 and 1100, one bit per step.
- Assert reset asynchronously between clock edges at bin=1010.
  - bin, gray and wrap read 0 before the next edge and stay 0 while reset is high.
  - First up step after release gives bin=0001, gray=0001.
- Random enable/up/load stimulus for 2000 cycles with a scoreboard.
  - gray equals the encoding of bin every cycle.
  - Every non-load step has a Hamming distance of 1.
  - wrap matches the reference model.

Source files
------------

// File: rtl/gray_code_counter.sv
// -----------------------------------------------------------------------------
// gray_code_counter
//
// Up/down binary counter whose value is re-encoded into reflected-binary Gray
// code on every edge. Intended for pointers that must change a single bit per
// step, e.g. FIFO pointers crossing a clock domain before being decoded back
// to binary on the far side.
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   asynchronous, active-high reset (clears bin, gray, wrap)
//   enable   in   advance the count one step on this edge
//   up       in   direction when enable=1: 1 = increment, 0 = decrement
//   load     in   synchronous parallel load, priority over enable
//   load_bin in   [WIDTH] binary value taken on load
//   bin      out  [WIDTH] registered binary count
//   gray     out  [WIDTH] registered Gray code of bin
//   wrap     out  one-cycle pulse the cycle after the count rolls over
// -----------------------------------------------------------------------------
module gray_code_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;

  // Next-state: load > enable > hold. Gray is derived from the next binary
  // value so both registers update together with no lag cycle.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (enable) begin
      if (up) begin
        bin_d  = bin_q + ONE;
        wrap_d = &bin_q;
      end else begin
        bin_d  = bin_q - ONE;
        wrap_d = ~|bin_q;
      end
    end
    gray_d = bin2gray(bin_d);
  end

  // Register stage: all outputs come straight from flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_code_counter.sv
module tb_gray_code_counter;

  localparam int WIDTH = 4;
  localparam int N     = 1 << WIDTH;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;
  logic             wrap;

  int passes = 0;
  int total  = 0;

  gray_code_counter #(.WIDTH(WIDTH)) dut (
    .clock   (clk),
    .reset   (reset),
    .enable  (enable),
    .up      (up),
    .load    (load),
    .load_bin(load_bin),
    .bin     (bin),
    .gray    (gray),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
  endtask

  // Gray code built bit by bit: bit i is set when binary bits i and i+1 differ.
  function automatic int enc(input int b);
    int g = 0;
    for (int i = 0; i < WIDTH; i++)
      if ((((b >> i) & 1) ^ ((b >> (i + 1)) & 1)) != 0) g |= (1 << i);
    return g;
  endfunction

  // Behavioural reference: an integer count modulo N.
  int mbin  = 0;
  int mwrap = 0;
  bit mstep = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mbin = 0; mwrap = 0; mstep = 0;
    end else if (load) begin
      mbin = int'(load_bin); mwrap = 0; mstep = 0;
    end else if (enable) begin
      mstep = 1;
      if (up) begin
        mwrap = (mbin == N - 1) ? 1 : 0;
        mbin  = (mbin + 1) % N;
      end else begin
        mwrap = (mbin == 0) ? 1 : 0;
        mbin  = (mbin + N - 1) % N;
      end
    end else begin
      mwrap = 0; mstep = 0;
    end
  end

  // Cycle-by-cycle comparison against the model, sampled mid-cycle.
  int prev_gray = 0;
  always @(negedge clk) begin
    chk("model_bin", int'(bin), mbin);
    chk("model_gray", int'(gray), enc(mbin));
    chk("model_wrap", int'(wrap), mwrap);
    if (mstep) chk("hamming1", $countones(gray ^ prev_gray[WIDTH-1:0]), 1);
    prev_gray = int'(gray);
  end

  task automatic cyc(input bit en, input bit u, input bit ld, input int lb);
    enable   = en;
    up       = u;
    load     = ld;
    load_bin = lb[WIDTH-1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic expect3(input string nm, input int b, input int g, input int w);
    chk({nm, "_bin"}, int'(bin), b);
    chk({nm, "_gray"}, int'(gray), g);
    chk({nm, "_wrap"}, int'(wrap), w);
  endtask

  int exp_up [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                      4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                      4'b1011, 4'b1001, 4'b1000, 4'b0000};

  initial begin
    reset = 1'b1; enable = 0; up = 0; load = 0; load_bin = '0;
    @(posedge clk); @(posedge clk); #1;
    expect3("reset", 0, 0, 0);
    #2 reset = 1'b0;

    // Count up through a full cycle.
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, 0, 0);
      chk("up_seq_gray", int'(gray), exp_up[i]);
      chk("up_seq_wrap", int'(wrap), (i == 15) ? 1 : 0);
    end

    // Down from zero wraps to all-ones.
    #2 reset = 1'b1; #2 reset = 1'b0;
    cyc(1, 0, 0, 0);
    expect3("down_wrap", 4'b1111, 4'b1000, 1);
    cyc(1, 0, 0, 0);
    expect3("down_next", 4'b1110, 4'b1001, 0);

    // Load beats enable.
    cyc(1, 1, 1, 4'b0101);
    expect3("load_prio", 4'b0101, 4'b0111, 0);
    cyc(1, 1, 0, 0);
    expect3("after_load", 4'b0110, 4'b0101, 0);
    cyc(1, 1, 0, 0);
    expect3("to_0111", 4'b0111, 4'b0100, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0);
      expect3("hold", 4'b0111, 4'b0100, 0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 0, 0);
      expect3("alt_up", 4'b1000, 4'b1100, 0);
      cyc(1, 0, 0, 0);
      expect3("alt_dn", 4'b0111, 4'b0100, 0);
    end

    // Up/down alternation across the boundary wraps on both steps.
    cyc(0, 0, 1, 4'b1111);
    cyc(1, 1, 0, 0);
    expect3("bnd_up", 0, 0, 1);
    cyc(1, 0, 0, 0);
    expect3("bnd_dn", 4'b1111, 4'b1000, 1);

    // Asynchronous reset between edges.
    cyc(0, 0, 1, 4'b1010);
    expect3("pre_rst", 4'b1010, 4'b1111, 0);
    enable = 1; up = 1; load = 0;
    #2 reset = 1'b1;
    #1;
    expect3("async_rst", 0, 0, 0);
    @(posedge clk); #1;
    expect3("rst_hold", 0, 0, 0);
    #2 reset = 1'b0;
    cyc(1, 1, 0, 0);
    expect3("post_rst", 4'b0001, 4'b0001, 0);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 15) == 0, int'($urandom_range(0, N - 1)));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
